// File: rtl/alu_fifo_pipeline.sv
// Multi-operation ALU fed by three show-ahead input FIFOs (A, B, opcode) and
// draining through a one-entry result stage into an output FIFO with flags.

module alu_fifo_pipeline_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Full refuses a push even if a pop happens in the same cycle.
  assign push_ok = push && (count != FULL_CNT);
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= push_data;
  end
endmodule

module alu_fifo_pipeline #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [2:0]        op_data,
  input  logic              op_valid,
  output logic              op_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_flags,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count,
  output logic [CNT_W-1:0]  out_count
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Packs {ovf, carry, zero, result}; ovf uses explicitly signed widened sums.
  function automatic logic [DATA_W+2:0] alu_eval(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [2:0]        op);
    logic        [DATA_W:0]   wide;
    logic signed [DATA_W:0]   s_wide;
    logic        [DATA_W-1:0] r;
    logic                     carry;
    logic                     ovf;
    wide   = '0;
    s_wide = '0;
    r      = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      3'd0: begin
        wide   = {1'b0, a} + {1'b0, b};
        s_wide = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        r      = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        ovf    = s_wide[DATA_W] != s_wide[DATA_W-1];
      end
      3'd1: begin
        wide   = {1'b0, a} - {1'b0, b};
        s_wide = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
        r      = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        ovf    = s_wide[DATA_W] != s_wide[DATA_W-1];
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = a << b[SH_W-1:0];
      3'd6:    r = a >> b[SH_W-1:0];
      default: r = (a > b) ? a : b;
    endcase
    return {ovf, carry, (r == '0), r};
  endfunction

  logic [DATA_W-1:0] a_head;
  logic [DATA_W-1:0] b_head;
  logic [2:0]        op_head;
  logic [CNT_W-1:0]  op_count;
  logic [DATA_W+2:0] out_head;
  logic [DATA_W+2:0] alu_p0;
  logic [DATA_W-1:0] result_p1;
  logic [2:0]        flags_p1;
  logic              vld_p1;
  logic              drain;
  logic              fire;

  alu_fifo_pipeline_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_a_fifo (
    .clk(clk_i), .rst(rst_i), .push(a_valid), .push_data(a_data),
    .pop(fire), .head(a_head), .count(a_count)
  );

  alu_fifo_pipeline_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_b_fifo (
    .clk(clk_i), .rst(rst_i), .push(b_valid), .push_data(b_data),
    .pop(fire), .head(b_head), .count(b_count)
  );

  alu_fifo_pipeline_fifo #(.DATA_W(3), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_op_fifo (
    .clk(clk_i), .rst(rst_i), .push(op_valid), .push_data(op_data),
    .pop(fire), .head(op_head), .count(op_count)
  );

  assign a_ready  = a_count != FULL_CNT;
  assign b_ready  = b_count != FULL_CNT;
  assign op_ready = op_count != FULL_CNT;

  // p0: join of the three FIFO heads; a slot frees up when the stage drains this cycle.
  assign drain  = vld_p1 && (out_count != FULL_CNT);
  assign fire   = (a_count != '0) && (b_count != '0) && (op_count != '0) && (!vld_p1 || drain);
  assign alu_p0 = alu_eval(a_head, b_head, op_head);

  always_ff @(posedge clk_i) begin
    if (rst_i)      vld_p1 <= 1'b0;
    else if (fire)  vld_p1 <= 1'b1;
    else if (drain) vld_p1 <= 1'b0;
  end

  // p1: registered result stage.
  always_ff @(posedge clk_i) begin
    if (fire) begin
      result_p1 <= alu_p0[DATA_W-1:0];
      flags_p1  <= alu_p0[DATA_W+2:DATA_W];
    end
  end

  alu_fifo_pipeline_fifo #(.DATA_W(DATA_W + 3), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_out_fifo (
    .clk(clk_i), .rst(rst_i), .push(drain), .push_data({flags_p1, result_p1}),
    .pop(res_ready), .head(out_head), .count(out_count)
  );

  assign res_valid = out_count != '0;
  assign res_data  = res_valid ? out_head[DATA_W-1:0] : '0;
  assign res_flags = res_valid ? out_head[DATA_W+2:DATA_W] : 3'b000;
endmodule

// File: tb/tb_alu_fifo_pipeline.sv
// Bench for alu_fifo_pipeline: directed latency/flag/skew/backpressure/reset
// scenarios plus a randomized stream scored against a queue-based model.

module tb_alu_fifo_pipeline;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, op_valid;
  logic       a_ready, b_ready, op_ready;
  logic [2:0] op_data;
  logic [7:0] res_data;
  logic [2:0] res_flags;
  logic       res_valid, res_ready;
  logic [2:0] a_count, b_count, out_count;

  int checks = 0;
  int failures = 0;

  alu_fifo_pipeline #(.DATA_W(8), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
    .res_data(res_data), .res_flags(res_flags), .res_valid(res_valid), .res_ready(res_ready),
    .a_count(a_count), .b_count(b_count), .out_count(out_count)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, carry, zero, result} computed with plain integer arithmetic.
  function automatic logic [10:0] ref_alu(input int a, input int b, input int op);
    int r, sa, sb, sr;
    logic c, v;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r = 0; sr = 0; c = 1'b0; v = 1'b0;
    case (op)
      0: begin r = a + b; c = r > 255; sr = sa + sb; v = (sr > 127) || (sr < -128); r = r % 256; end
      1: begin r = a - b; c = a < b; sr = sa - sb; v = (sr > 127) || (sr < -128); if (r < 0) r += 256; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << (b % 8)) % 256;
      6: r = a >> (b % 8);
      default: r = (a > b) ? a : b;
    endcase
    return {v, c, (r == 0), 8'(r)};
  endfunction

  task automatic drive3(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    a_data = a; b_data = b; op_data = op;
    a_valid = 1'b1; b_valid = 1'b1; op_valid = 1'b1;
  endtask

  task automatic idle3();
    a_valid = 1'b0; b_valid = 1'b0; op_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] ed, input logic [2:0] ef);
    res_ready = 1'b1;
    drive3(a, b, op);
    step();
    idle3();
    step();
    chk({tag, "_c2_valid"}, 32'(res_valid), 32'd0);
    step();
    chk({tag, "_c3_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_c3_data"}, 32'(res_data), 32'(ed));
    chk({tag, "_c3_flags"}, 32'(res_flags), 32'(ef));
    step();
    chk({tag, "_c4_popped"}, 32'(res_valid), 32'd0);
  endtask

  logic [10:0] expq[$];
  int qa[$], qb[$], qo[$];
  logic [10:0] e;
  logic fa, fb, fo;
  int k, n;

  initial begin
    rst_i = 1'b1; res_ready = 1'b0;
    a_data = '0; b_data = '0; op_data = '0;
    idle3();
    step();
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_count", 32'(b_count), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_flags", 32'(res_flags), 32'd0);
    chk("rst_readies", 32'({a_ready, b_ready, op_ready}), 32'd7);
    rst_i = 1'b0;
    step();

    run_one("add_carry", 8'd200, 8'd100, 3'd0, 8'd44, 3'b010);

    // Back-to-back SUB: results on consecutive cycles 3 and 4.
    res_ready = 1'b1;
    drive3(8'd5, 8'd5, 3'd1);
    step();
    drive3(8'd3, 8'd5, 3'd1);
    step();
    idle3();
    step();
    chk("sub0_valid", 32'(res_valid), 32'd1);
    chk("sub0_data", 32'(res_data), 32'd0);
    chk("sub0_flags", 32'(res_flags), 32'b001);
    step();
    chk("sub1_valid", 32'(res_valid), 32'd1);
    chk("sub1_data", 32'(res_data), 32'd254);
    chk("sub1_flags", 32'(res_flags), 32'b010);
    step();
    chk("sub_empty", 32'(res_valid), 32'd0);

    run_one("add_ovf", 8'd100, 8'd100, 3'd0, 8'd200, 3'b100);
    run_one("sll", 8'h81, 8'd9, 3'd5, 8'h02, 3'b000);
    run_one("maxu", 8'd7, 8'd250, 3'd7, 8'd250, 3'b000);
    run_one("srl", 8'hF0, 8'd4, 3'd6, 8'h0F, 3'b000);
    run_one("xor_zero", 8'h5A, 8'h5A, 3'd4, 8'h00, 3'b001);

    // Skew: A at cycle 0, op at cycle 2, B at cycle 5.
    res_ready = 1'b1;
    a_data = 8'd1; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    chk("skew_c1_acount", 32'(a_count), 32'd1);
    op_data = 3'd0; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    step();
    step();
    chk("skew_c4_acount", 32'(a_count), 32'd1);
    b_data = 8'd2; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    chk("skew_c6_acount", 32'(a_count), 32'd1);
    chk("skew_c6_valid", 32'(res_valid), 32'd0);
    step();
    chk("skew_c7_acount", 32'(a_count), 32'd0);
    chk("skew_c7_valid", 32'(res_valid), 32'd0);
    step();
    chk("skew_c8_valid", 32'(res_valid), 32'd1);
    chk("skew_c8_data", 32'(res_data), 32'd3);
    step();

    // Backpressure: nine in flight (4 out + 1 stage + 4 input) before a_ready drops.
    res_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_ready) begin
        drive3(8'($urandom), 8'($urandom), 3'($urandom));
        expq.push_back(ref_alu(int'(a_data), int'(b_data), int'(op_data)));
        k++;
      end else begin
        idle3();
      end
      step();
    end
    idle3();
    chk("bp_accepted", 32'(k), 32'd9);
    chk("bp_out_count", 32'(out_count), 32'd4);
    chk("bp_a_count", 32'(a_count), 32'd4);
    chk("bp_a_ready", 32'(a_ready), 32'd0);
    res_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (res_valid) begin
        if (expq.size() == 0) chk("bp_extra_output", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("bp_data", 32'(res_data), 32'(e[7:0]));
          chk("bp_flags", 32'(res_flags), 32'(e[10:8]));
        end
        n++;
      end
      step();
    end
    chk("bp_drained", 32'(n), 32'd9);

    // Reset mid-stream with every FIFO occupied; handshakes during reset ignored.
    res_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive3(8'($urandom), 8'($urandom), 3'($urandom));
      step();
    end
    chk("mid_pre_nonempty", 32'((a_count != 0) && (out_count != 0)), 32'd1);
    rst_i = 1'b1; res_ready = 1'b1;
    step();
    rst_i = 1'b0; idle3();
    chk("mid_a_count", 32'(a_count), 32'd0);
    chk("mid_b_count", 32'(b_count), 32'd0);
    chk("mid_out_count", 32'(out_count), 32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_readies", 32'({a_ready, b_ready, op_ready}), 32'd7);
    step();
    chk("mid_still_empty", 32'({a_count, out_count, res_valid}), 32'd0);
    run_one("post_rst_add", 8'd1, 8'd1, 3'd0, 8'd2, 3'b000);

    // Randomized stream with independent valids and random backpressure.
    for (int c = 0; c < 400; c++) begin
      if (!a_valid) begin a_valid = 1'($urandom % 2); a_data = 8'($urandom); end
      if (!b_valid) begin b_valid = 1'($urandom % 2); b_data = 8'($urandom); end
      if (!op_valid) begin op_valid = 1'($urandom % 2); op_data = 3'($urandom); end
      res_ready = ($urandom % 4) != 0;
      if (res_valid && res_ready) begin
        if (expq.size() == 0) chk("rnd_extra_output", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("rnd_data", 32'(res_data), 32'(e[7:0]));
          chk("rnd_flags", 32'(res_flags), 32'(e[10:8]));
        end
      end
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      fo = op_valid && op_ready;
      step();
      if (fa) begin qa.push_back(int'(a_data)); a_valid = 1'b0; end
      if (fb) begin qb.push_back(int'(b_data)); b_valid = 1'b0; end
      if (fo) begin qo.push_back(int'(op_data)); op_valid = 1'b0; end
      while (qa.size() > 0 && qb.size() > 0 && qo.size() > 0)
        expq.push_back(ref_alu(qa.pop_front(), qb.pop_front(), qo.pop_front()));
    end
    idle3();
    res_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (res_valid) begin
        if (expq.size() == 0) chk("rnd_extra_output", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("rnd_drain_data", 32'(res_data), 32'(e[7:0]));
          chk("rnd_drain_flags", 32'(res_flags), 32'(e[10:8]));
        end
      end
      step();
    end
    chk("rnd_all_results_seen", 32'(expq.size()), 32'd0);
    chk("rnd_a_leftover", 32'(a_count), 32'(qa.size()));
    chk("rnd_b_leftover", 32'(b_count), 32'(qb.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_fifo_pipeline.md
Name: alu_fifo_pipeline

Overview:
- Parametrised successor to the two-operand adder-with-FIFOs datapath.
- Three input FIFOs feed operand A, operand B and a per-transaction opcode, so the datapath is a multi-operation ALU rather than a fixed adder.
- Results pass through a registered ALU stage into an output FIFO carrying status flags.
- FIFO depth and data width are parameters, and every FIFO exposes its fill level for flow monitoring.

Parameters:
- DATA_W, 8, operand/result width (>=4).
- DEPTH, 4, entries per FIFO (all four FIFOs); power of two, >=2.
- CNT_W, $clog2(DEPTH)+1, derived; fill-level width.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset: one clock; reset is synchronous and active-high.
- a_data  in  DATA_W  operand A.
- a_valid  in  1  A push request.
- a_ready  out  1  A FIFO not full.
- b_data  in  DATA_W  operand B.
- b_valid  in  1  B push request.
- b_ready  out  1  B FIFO not full.
- op_data  in  3  opcode.
- op_valid  in  1  opcode push request.
- op_ready  out  1  opcode FIFO not full.
- res_data  out  DATA_W  result at output FIFO head.
- res_flags  out  3  {ovf, carry, zero} of the head entry.
- res_valid  out  1  output FIFO not empty.
- res_ready  in  1  consumer accepts head.
- a_count, b_count, out_count  out  CNT_W  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Handshake: transfer occurs on any rising edge where valid && ready. A producer holding valid may not change data until the transfer. ready does not depend combinationally on valid.
- FIFOs: show-ahead; head data are valid whenever the FIFO is non-empty. ready = (count != DEPTH). A push is visible at the head on the following cycle; there is no same-cycle bypass. Simultaneous push and pop at partial fill leaves count unchanged. When full, a pop plus push in the same cycle is refused (ready already low). Pointers wrap modulo DEPTH.
- Join/fire: the ALU stage fires when A, B and op FIFOs are all non-empty AND (stage empty OR stage result is being written into the output FIFO this cycle). On fire, one entry is popped from each of the three input FIFOs simultaneously; operands are never consumed individually.
- Stage: a one-entry register {result, flags, valid}. It is written into the output FIFO when valid and the output FIFO is not full. With no backpressure the stage sustains 1 op/cycle.
- Latency: with all three pushed in cycle 0 and all FIFOs empty, res_valid=1 in cycle 3 (input FIFO +1, stage +1, output FIFO +1).
- Opcodes (unsigned unless noted):
  - 0 ADD: A+B, carry = bit DATA_W.
  - 1 SUB: A-B, carry = borrow (A<B).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: A << B[$clog2(DATA_W)-1:0].
  - 6 SRL: A >> same.
  - 7 MAXU: larger of A,B.
  - carry=0 for opcodes 2-7.
- Flags: ovf = two's-complement signed overflow for ADD/SUB only, else 0. zero = (result==0) for all ops. Results are truncated to DATA_W.
- Reset: all counts 0, all pointers 0, stage invalid, res_valid=0, a/b/op_ready=1 on the cycle after rst_i is sampled high. res_data/res_flags are 0 while empty. Reset mid-operation discards all in-flight data, and no partial result is emitted. Handshakes in a cycle where rst_i=1 are ignored.
- Skew: arrival order across A/B/op is unconstrained; pairing is strictly by per-FIFO order.

Test Plan:
- DATA_W=8: push A=200, B=100, op=0 in cycle 0, res_ready=1 -> cycle 3: res_valid=1, res_data=44, flags {ovf0,carry1,zero0}; popped the next cycle.
- op=1 with A=5,B=5 then A=3,B=5 back-to-back -> results 0 {0,0,1}, then 254 {0,1,0}, on consecutive cycles 3 and 4.
- op=0 A=100,B=100 -> 200 {1,0,0}; op=5 A=0x81,B=9 -> 0x02 (shift 1) {0,0,0}; op=7 A=7,B=250 -> 250.
- Skew: A=1 at cycle 0, op=0 at cycle 2, B=2 at cycle 5 -> no fire before cycle 6; result 3 at cycle 8; a_count=1 during cycles 1-6.
- Backpressure, DEPTH=4, res_ready=0, stream of ops -> out_count saturates at 4, stage holds 1, a_ready falls after the 9th accepted A (input FIFOs full). Raising res_ready drains all 9 in order, no loss or duplication.
- Assert rst_i mid-stream with all FIFOs non-empty -> next cycle all counts 0, res_valid=0, readies 1. Fresh ADD 1+1 yields 2 at latency 3.
